led_controller: RTL and testbench

LED_CONTROLLER -- requirements
Module: led_controller

---
 rtl/led_ctrl_pkg.sv | 54 +++++
 rtl/led_controller_blink_prescaler.sv | 33 +++
 rtl/led_controller.sv | 151 +++++++++++++++
 tb/tb_led_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types, ASCII command bytes and mode helpers for the LED controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        OP_ON     = 2'd0,
        OP_OFF    = 2'd1,
        OP_BLINK  = 2'd2,
        OP_TOGGLE = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARG  = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_O    = 8'h6f;
    localparam logic [7:0] ASCII_F    = 8'h66;
    localparam logic [7:0] ASCII_B    = 8'h62;
    localparam logic [7:0] ASCII_T    = 8'h74;
    localparam logic [7:0] ASCII_R    = 8'h72;
    localparam logic [7:0] ASCII_STAR = 8'h2a;

    // Toggle never lands in BLINK: a blinking channel is switched off.
    function automatic mode_t apply_op(input op_t op, input mode_t cur);
        mode_t res;
        res = cur;
        case (op)
            OP_ON:     res = MODE_ON;
            OP_OFF:    res = MODE_OFF;
            OP_BLINK:  res = MODE_BLINK;
            OP_TOGGLE: res = (cur == MODE_OFF) ? MODE_ON : MODE_OFF;
            default:   res = cur;
        endcase
        return res;
    endfunction

    function automatic logic mode_to_led(input mode_t m, input logic phase);
        logic res;
        case (m)
            MODE_ON:    res = 1'b1;
            MODE_BLINK: res = phase;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_controller_blink_prescaler.sv
// Free-running divider producing the shared blink phase; wrap is high in the
// cycle whose clock edge will invert the phase.
module blink_prescaler #(
    parameter int DIV = 3_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic phase,
    output logic wrap
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt = '0;
    logic          phase_q = 1'b0;

    assign wrap  = (cnt == CNT_LAST);
    assign phase = phase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            phase_q <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_controller.sv
// Byte-driven LED controller: single-byte toggles, two-byte op+argument
// commands with an argument timeout, and lockstep blinking.
module led_controller
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS    = 5,
    parameter int BLINK_DIV   = 3_000_000,
    parameter int ARG_TIMEOUT = 12_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                ready,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy
);

    generate
        if (NUM_LEDS < 1 || NUM_LEDS > 9) begin : g_bad_num_leds
            $error("led_controller: NUM_LEDS must be in 1..9");
        end
        if (BLINK_DIV < 2) begin : g_bad_blink_div
            $error("led_controller: BLINK_DIV must be at least 2");
        end
        if (ARG_TIMEOUT < 2) begin : g_bad_arg_timeout
            $error("led_controller: ARG_TIMEOUT must be at least 2");
        end
    endgenerate

    localparam int TW = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(ARG_TIMEOUT - 1);

    mode_t               mode    [NUM_LEDS] = '{default: MODE_OFF};
    state_t              state   = ST_IDLE;
    op_t                 op      = OP_ON;
    logic [TW-1:0]       tcnt    = '0;
    logic [NUM_LEDS-1:0] leds_q  = '0;
    logic                busy_q  = 1'b0;

    mode_t               mode_nx [NUM_LEDS];
    state_t              state_nx;
    op_t                 op_nx;
    logic [TW-1:0]       tcnt_nx;
    logic [NUM_LEDS-1:0] leds_nx;
    logic [NUM_LEDS-1:0] sel;
    logic                is_digit;
    logic                phase;
    logic                wrap;
    logic                phase_nx;

    blink_prescaler #(
        .DIV (BLINK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .phase (phase),
        .wrap  (wrap)
    );

    // LEDs are registered, so they are built from the phase the prescaler
    // will hold after this edge; blinking channels then track it exactly.
    assign phase_nx = phase ^ wrap;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            sel[i] = (data == 8'(ASCII_0 + 8'(i + 1)));
        end
        is_digit = |sel;
    end

    always_comb begin
        state_nx = state;
        op_nx    = op;
        tcnt_nx  = tcnt;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_nx[i] = mode[i];
        end

        case (state)
            ST_IDLE: begin
                if (ready) begin
                    if (is_digit) begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (sel[i]) mode_nx[i] = apply_op(OP_TOGGLE, mode[i]);
                        end
                    end else begin
                        case (data)
                            ASCII_O: begin op_nx = OP_ON;     state_nx = ST_ARG; tcnt_nx = '0; end
                            ASCII_F: begin op_nx = OP_OFF;    state_nx = ST_ARG; tcnt_nx = '0; end
                            ASCII_B: begin op_nx = OP_BLINK;  state_nx = ST_ARG; tcnt_nx = '0; end
                            ASCII_T: begin op_nx = OP_TOGGLE; state_nx = ST_ARG; tcnt_nx = '0; end
                            ASCII_R: begin
                                for (int i = 0; i < NUM_LEDS; i++) begin
                                    mode_nx[i] = MODE_OFF;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_ARG: begin
                // A byte in the expiry cycle still counts as the argument.
                if (ready) begin
                    state_nx = ST_IDLE;
                    for (int i = 0; i < NUM_LEDS; i++) begin
                        if (sel[i] || data == ASCII_STAR) begin
                            mode_nx[i] = apply_op(op, mode[i]);
                        end
                    end
                end else if (tcnt == TCNT_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_nx[i] = mode_to_led(mode_nx[i], phase_nx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op     <= OP_ON;
            tcnt   <= '0;
            leds_q <= '0;
            busy_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= MODE_OFF;
            end
        end else begin
            state  <= state_nx;
            op     <= op_nx;
            tcnt   <= tcnt_nx;
            leds_q <= leds_nx;
            busy_q <= (state_nx == ST_ARG);
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode[i] <= mode_nx[i];
            end
        end
    end

    assign leds = leds_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller (NUM_LEDS=5, BLINK_DIV=4, ARG_TIMEOUT=8);
// inputs change and outputs are sampled on the falling edge.
module tb_led_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic [4:0] leds;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    // Reference blink phase: divide-by-4, phase inverts on each wrap.
    int   mcnt   = 0;
    logic mphase = 1'b0;

    led_controller #(
        .NUM_LEDS    (5),
        .BLINK_DIV   (4),
        .ARG_TIMEOUT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .ready (ready),
        .leds  (leds),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            mcnt   <= 0;
            mphase <= 1'b0;
        end else if (mcnt == 3) begin
            mcnt   <= 0;
            mphase <= ~mphase;
        end else begin
            mcnt <= mcnt + 1;
        end
    end

    task automatic apply_stimulus(input logic [7:0] b);
        data  = b;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (leds !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: leds=%b busy=%b expected leds=00000 busy=0", leds, busy);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] bytes [4] = '{"1", "3", "1", "r"};
        logic [4:0] exp   [4] = '{5'b00001, 5'b00101, 5'b00100, 5'b00000};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(bytes[i]);
            vectors++;
            if (leds !== exp[i] || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL toggle[%0d]: leds=%b busy=%b expected leds=%b busy=0", i, leds, busy, exp[i]);
            end
        end
    endtask

    task automatic test_on_off();
        logic [7:0] bytes [6] = '{"o", "*", "f", "2", "t", "*"};
        logic [4:0] exp   [6] = '{5'b00000, 5'b11111, 5'b11111, 5'b11101, 5'b11101, 5'b00010};
        logic       expb  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(bytes[i]);
            vectors++;
            if (leds !== exp[i] || busy !== expb[i]) begin
                errors++;
                $display("[TB] FAIL on_off[%0d]: leds=%b busy=%b expected leds=%b busy=%b", i, leds, busy, exp[i], expb[i]);
            end
        end
    endtask

    task automatic test_blink();
        int toggles = 0;
        logic prev;
        do_reset();
        apply_stimulus("b");
        apply_stimulus("4");
        prev = leds[3];
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (leds !== {1'b0, mphase, 3'b000} || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL blink[%0d]: leds=%b busy=%b expected leds=%b busy=0", i, leds, busy, {1'b0, mphase, 3'b000});
            end
            if (leds[3] !== prev) toggles++;
            prev = leds[3];
            idle(1);
        end
        vectors++;
        if (toggles < 3) begin
            errors++;
            $display("[TB] FAIL blink_toggles: saw %0d transitions expected at least 3", toggles);
        end
        apply_stimulus("4");
        vectors++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL blink_off: leds=%b expected 00000", leds);
        end
    endtask

    task automatic test_timeout();
        apply_stimulus("r");
        apply_stimulus("o");
        idle(7);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pending: busy=%b expected 1", busy);
        end
        idle(1);
        vectors++;
        if (busy !== 1'b0 || leds !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL timeout_expire: leds=%b busy=%b expected leds=00000 busy=0", leds, busy);
        end
        apply_stimulus("2");
        vectors++;
        if (leds !== 5'b00010 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_after: leds=%b busy=%b expected leds=00010 busy=0", leds, busy);
        end
        // Byte lands exactly in the expiry cycle and must act as the argument.
        apply_stimulus("o");
        idle(7);
        apply_stimulus("3");
        vectors++;
        if (leds !== 5'b00110 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_edge: leds=%b busy=%b expected leds=00110 busy=0", leds, busy);
        end
    endtask

    task automatic test_bad_arg();
        logic [7:0] bytes [9] = '{"r", "b", "x", "1", "7", "0", "6", "f", "o"};
        logic [4:0] exp   [9] = '{5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00001,
                                  5'b00001, 5'b00001, 5'b00001, 5'b00001};
        logic       expb  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(bytes[i]);
            vectors++;
            if (leds !== exp[i] || busy !== expb[i]) begin
                errors++;
                $display("[TB] FAIL bad_arg[%0d]: leds=%b busy=%b expected leds=%b busy=%b", i, leds, busy, exp[i], expb[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        apply_stimulus("5");
        vectors++;
        if (leds !== 5'b10001) begin
            errors++;
            $display("[TB] FAIL prio_setup: leds=%b expected 10001", leds);
        end
        reset = 1'b1;
        data  = "1";
        ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b0;
        data  = 8'h00;
        vectors++;
        if (leds !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_reset: leds=%b busy=%b expected leds=00000 busy=0", leds, busy);
        end
        apply_stimulus("o");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (leds !== 5'b00000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_mid_arg: leds=%b busy=%b expected leds=00000 busy=0", leds, busy);
        end
        apply_stimulus("2");
        vectors++;
        if (leds !== 5'b00010 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_after: leds=%b busy=%b expected leds=00010 busy=0", leds, busy);
        end
        apply_stimulus("2");
        vectors++;
        if (leds !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL prio_toggle_back: leds=%b expected 00000", leds);
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_on_off();
        test_blink();
        test_timeout();
        test_bad_arg();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
